// File: rtl/ca_run_ctrl.sv
// rtl/ca_run_ctrl.sv - rule110 run controller; CA_HALT_ON_STABLE_EN adds halt-on-fixed-point
module ca_run_ctrl #(
    parameter int N     = 512,
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_seed,
    input  logic [GEN_W-1:0] cmd_gen,
    input  logic             abort,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_q,
    output logic [GEN_W-1:0] res_gen,
    output logic             res_aborted,
    output logic             res_stable,
    output logic             busy,
    output logic             ca_load,
    output logic [N-1:0]     ca_data,
    input  logic [N-1:0]     ca_q
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CAPT, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [GEN_W-1:0] cnt_q, cnt_d;
    logic [GEN_W-1:0] tgt_q, tgt_d;
    logic [GEN_W-1:0] res_gen_q, res_gen_d;
    logic [N-1:0]     work_q, work_d;
    logic [N-1:0]     res_data_q, res_data_d;
    logic             res_aborted_q, res_aborted_d;
    logic             res_stable_q, res_stable_d;
    logic             ca_load_q, cmd_ready_q, res_valid_q, busy_q;
    logic             stable_hit;

`ifdef CA_HALT_ON_STABLE_EN
    logic [N-1:0] prev_q, prev_d;

    assign stable_hit = (cnt_q != '0) && (ca_q == prev_q);

    always_comb begin
        prev_d = prev_q;
        if (state_q == S_RUN) begin
            prev_d = ca_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end
`else
    assign stable_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tgt_d         = tgt_q;
        work_d        = work_q;
        res_data_d    = res_data_q;
        res_gen_d     = res_gen_q;
        res_aborted_d = res_aborted_q;
        res_stable_d  = res_stable_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    work_d        = cmd_seed;
                    tgt_d         = cmd_gen;
                    cnt_d         = '0;
                    res_aborted_d = 1'b0;
                    res_stable_d  = 1'b0;
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (tgt_q == '0) ? S_CAPT : S_RUN;
            end
            S_RUN: begin
                // Abort beats a fixed point; a fixed point keeps cnt at c so CAPT reports c
                if (abort) begin
                    cnt_d         = cnt_q + 1'b1;
                    res_aborted_d = 1'b1;
                    state_d       = S_CAPT;
                end else if (stable_hit) begin
                    res_stable_d = 1'b1;
                    state_d      = S_CAPT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == tgt_q - 1'b1) begin
                        state_d = S_CAPT;
                    end
                end
            end
            S_CAPT: begin
                res_data_d = ca_q;
                res_gen_d  = cnt_q;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // CAPT feeds q straight back so the core holds the generation being captured
    always_comb begin
        ca_data = res_data_q;
        case (state_q)
            S_LOAD, S_RUN: ca_data = work_q;
            S_CAPT:        ca_data = ca_q;
            default:       ca_data = res_data_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tgt_q         <= '0;
            work_q        <= '0;
            res_data_q    <= '0;
            res_gen_q     <= '0;
            res_aborted_q <= 1'b0;
            res_stable_q  <= 1'b0;
            ca_load_q     <= 1'b1;
            cmd_ready_q   <= 1'b1;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tgt_q         <= tgt_d;
            work_q        <= work_d;
            res_data_q    <= res_data_d;
            res_gen_q     <= res_gen_d;
            res_aborted_q <= res_aborted_d;
            res_stable_q  <= res_stable_d;
            ca_load_q     <= (state_d != S_RUN);
            cmd_ready_q   <= (state_d == S_IDLE);
            res_valid_q   <= (state_d == S_DONE);
            busy_q        <= (state_d != S_IDLE);
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign res_valid   = res_valid_q;
    assign res_q       = res_data_q;
    assign res_gen     = res_gen_q;
    assign res_aborted = res_aborted_q;
    assign res_stable  = res_stable_q;
    assign busy        = busy_q;
    assign ca_load     = ca_load_q;

endmodule
